// File: rtl/i_ram_loader_pkg.sv
// Shared definitions for the instruction RAM boot loader.
// State encoding and stream framing constants.
package i_ram_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/i_ram_byte_assembler.sv
// Packs MSB-first bytes into 32-bit words.
// word_valid is combinational on the 4th byte.
module i_ram_byte_assembler
  import i_ram_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] sr;

  assign word_valid = take && (idx == 2'(BYTES_PER_WORD - 1));
  assign word       = {sr, byte_in};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
      sr  <= '0;
    end else if (clear) begin
      idx <= '0;
      sr  <= '0;
    end else if (take) begin
      idx <= idx + 2'd1;
      sr  <= {sr[15:0], byte_in};
    end
  end

endmodule

// File: rtl/i_ram_program_loader.sv
// Boot loader: byte stream -> instruction RAM, holds CPU.
// Optional trailing XOR checksum: I_RAM_LOADER_CHECKSUM_EN.
module i_ram_program_loader
  import i_ram_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] i_ram_writing_address,
  output logic [DATA_W-1:0] i_ram_input,
  output logic              flag_write_i_ram,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t            state, state_nx;
  logic              take, go, last_word;
  logic              hdr_idx;
  logic [7:0]        hdr_msb;
  logic [15:0]       hdr_word;
  logic [ADDR_W-1:0] n_words;
  logic              word_valid;
  logic [31:0]       asm_word;
`ifdef I_RAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign byte_ready = (state == S_HDR) || (state == S_LOAD) ||
                      (state == S_CHK);
  assign take       = byte_valid && byte_ready;
  assign go         = start && ((state == S_IDLE) ||
                      (state == S_DONE) || (state == S_ERROR));
  assign hdr_word   = {hdr_msb, byte_in};
  assign last_word  = word_valid &&
                      (words_loaded == n_words - ADDR_W'(1));
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);
  assign cpu_hold   = (state != S_DONE);

  i_ram_byte_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (go),
    .take       (take && (state == S_LOAD)),
    .byte_in    (byte_in),
    .word_valid (word_valid),
    .word       (asm_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_nx = S_HDR;
      S_HDR:
        if (take && hdr_idx) begin
          if (hdr_word[15:10] != 6'd0 || hdr_word > DEPTH_W)
            state_nx = S_ERROR;
          else if (hdr_word == 16'd0)
            state_nx = S_DONE;
          else
            state_nx = S_LOAD;
        end
      S_LOAD:
`ifdef I_RAM_LOADER_CHECKSUM_EN
        if (last_word) state_nx = S_CHK;
      S_CHK:
        if (take) state_nx = (byte_in == csum) ? S_DONE : S_ERROR;
`else
        if (last_word) state_nx = S_DONE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr_idx               <= 1'b0;
      hdr_msb               <= '0;
      n_words               <= '0;
      words_loaded          <= '0;
      i_ram_writing_address <= '0;
      i_ram_input           <= '0;
      flag_write_i_ram      <= 1'b0;
    end else begin
      flag_write_i_ram <= 1'b0;
      if (go) begin
        hdr_idx      <= 1'b0;
        words_loaded <= '0;
      end
      if (state == S_HDR && take) begin
        hdr_idx <= ~hdr_idx;
        hdr_msb <= byte_in;
        if (hdr_idx) n_words <= ADDR_W'(hdr_word);
      end
      // Address uses the pre-increment count of the word being written
      if (word_valid) begin
        flag_write_i_ram      <= 1'b1;
        i_ram_writing_address <= ADDR_W'(BASE_ADDR) + words_loaded;
        i_ram_input           <= asm_word;
        words_loaded          <= words_loaded + ADDR_W'(1);
      end
    end
  end

`ifdef I_RAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        csum <= '0;
    else if (go)                      csum <= '0;
    else if (state == S_LOAD && take) csum <= csum ^ byte_in;
  end
`endif

endmodule

// File: tb/tb_i_ram_program_loader.sv
// Directed bench for i_ram_program_loader.
// Checksum scenario only when I_RAM_LOADER_CHECKSUM_EN is defined.
module tb_i_ram_program_loader;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] i_ram_writing_address;
  logic [31:0]   i_ram_input;
  logic          flag_write_i_ram;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;
  logic [AW-1:0] words_loaded;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int wr_base;

  i_ram_program_loader dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .byte_in               (byte_in),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .i_ram_writing_address (i_ram_writing_address),
    .i_ram_input           (i_ram_input),
    .flag_write_i_ram      (flag_write_i_ram),
    .cpu_hold              (cpu_hold),
    .load_done             (load_done),
    .load_error            (load_error),
    .words_loaded          (words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (flag_write_i_ram) wr_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit exp_wr,
                           input logic [AW-1:0] exp_addr,
                           input logic [31:0] exp_data);
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick;
      checks++;
      if (flag_write_i_ram !== 1'b0) begin
        errors++;
        $display("FAIL gap_strobe: got %b required 0", flag_write_i_ram);
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    tick;
    byte_valid = 1'b0;
    checks++;
    if (flag_write_i_ram !== exp_wr) begin
      errors++;
      $display("FAIL strobe: byte %h got %b required %b",
               b, flag_write_i_ram, exp_wr);
    end
    if (exp_wr) begin
      checks++;
      if (i_ram_writing_address !== exp_addr ||
          i_ram_input !== exp_data) begin
        errors++;
        $display("FAIL write: got %0d/%h required %0d/%h",
                 i_ram_writing_address, i_ram_input, exp_addr, exp_data);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap,
                           input logic [AW-1:0] addr);
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], gap, k == 3, addr, w);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8], 0, 1'b0, '0, '0);
    send_byte(n[7:0], 0, 1'b0, '0, '0);
  endtask

  task automatic check_status(input string name, input logic done,
                              input logic err, input logic hold,
                              input logic rdy);
    checks++;
    if ({load_done, load_error, cpu_hold, byte_ready} !==
        {done, err, hold, rdy}) begin
      errors++;
      $display("FAIL %s: done/err/hold/rdy got %b%b%b%b required %b%b%b%b",
               name, load_done, load_error, cpu_hold, byte_ready,
               done, err, hold, rdy);
    end
  endtask

  task automatic check_words(input string name, input int exp_n,
                             input int exp_wr);
    tick;
    checks++;
    if (words_loaded !== AW'(exp_n) || (wr_count - wr_base) != exp_wr) begin
      errors++;
      $display("FAIL %s: words_loaded %0d writes %0d required %0d %0d",
               name, words_loaded, wr_count - wr_base, exp_n, exp_wr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) tick;
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (flag_write_i_ram !== 1'b0 || words_loaded !== '0 ||
        i_ram_writing_address !== '0 || i_ram_input !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wr %b n %0d a %0d d %h required 0",
               flag_write_i_ram, words_loaded,
               i_ram_writing_address, i_ram_input);
    end
    reset = 1'b0;
    tick;
    send_byte(8'hAA, 0, 1'b0, '0, '0);
    check_status("idle_ignores_bytes", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_basic_load;
    wr_base = wr_count;
    pulse_start;
    check_status("hdr_entry", 1'b0, 1'b0, 1'b1, 1'b1);
    send_hdr(16'h0003);
    send_word(32'hDEADBEEF, 0, 0);
    send_word(32'h01234567, 0, 1);
    send_word(32'h89ABCDEF, 0, 2);
    check_status("basic_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_words("basic_count", 3, 3);
  endtask

  task automatic test_empty_image;
    pulse_start;
    check_status("restart_clears", 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (words_loaded !== '0) begin
      errors++;
      $display("FAIL restart_words: got %0d required 0", words_loaded);
    end
    wr_base = wr_count;
    send_hdr(16'h0000);
    check_status("empty_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_words("empty_count", 0, 0);
  endtask

  task automatic test_header_error;
    wr_base = wr_count;
    pulse_start;
    send_hdr(16'h0015);
    check_status("too_big", 1'b0, 1'b1, 1'b1, 1'b0);
    check_words("too_big_writes", 0, 0);
    pulse_start;
    check_status("err_restart", 1'b0, 1'b0, 1'b1, 1'b1);
    send_hdr(16'h0401);
    check_status("upper_bits", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start;
    send_hdr(16'h0014);
    check_status("depth_ok", 1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick;
    wr_base = wr_count;
    pulse_start;
    send_hdr(16'h0001);
    send_word(32'hCAFEF00D, 0, 0);
    check_status("recover_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_words("recover_count", 1, 1);
  endtask

  task automatic test_gaps_and_start;
    wr_base = wr_count;
    pulse_start;
    send_hdr(16'h0002);
    send_byte(8'h11, 1, 1'b0, '0, '0);
    send_byte(8'h22, 2, 1'b0, '0, '0);
    pulse_start;
    check_status("start_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h33, 3, 1'b0, '0, '0);
    send_byte(8'h44, 1, 1'b1, 0, 32'h11223344);
    send_word(32'hA5C3_0F96, 2, 1);
    check_status("gap_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_words("gap_count", 2, 2);
  endtask

  task automatic test_reset_mid_load;
    pulse_start;
    send_hdr(16'h0004);
    send_word(32'h10203040, 0, 0);
    send_word(32'h50607080, 0, 1);
    reset = 1'b1;
    #1;
    checks++;
    if (flag_write_i_ram !== 1'b0 || cpu_hold !== 1'b1 ||
        byte_ready !== 1'b0 || words_loaded !== '0) begin
      errors++;
      $display("FAIL async_reset: wr %b hold %b rdy %b n %0d required 0 1 0 0",
               flag_write_i_ram, cpu_hold, byte_ready, words_loaded);
    end
    tick;
    reset = 1'b0;
    check_status("reset_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    wr_base = wr_count;
    pulse_start;
    send_hdr(16'h0002);
    send_word(32'hFFFF0000, 0, 0);
    send_word(32'h0000FFFF, 0, 1);
    check_status("reload_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_words("reload_count", 2, 2);
  endtask

`ifdef I_RAM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    wr_base = wr_count;
    pulse_start;
    send_hdr(16'h0001);
    send_word(32'h12345678, 0, 0);
    check_status("chk_wait", 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h08, 0, 1'b0, '0, '0);
    check_status("chk_good", 1'b1, 1'b0, 1'b0, 1'b0);
    wr_base = wr_count;
    pulse_start;
    send_hdr(16'h0001);
    send_word(32'h12345678, 0, 0);
    send_byte(8'h09, 0, 1'b0, '0, '0);
    check_status("chk_bad", 1'b0, 1'b1, 1'b1, 1'b0);
    check_words("chk_bad_writes", 1, 1);
  endtask
`endif

  initial begin
    test_reset;
    test_basic_load;
    test_empty_image;
    test_header_error;
    test_gaps_and_start;
    test_reset_mid_load;
`ifdef I_RAM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
